// File: rtl/bcd_operand_entry.sv
// Keypad-driven entry of two packed-BCD operands plus add/subtract select, handed on via valid/ready.
// Optional backspace (key code 14) is enabled by defining BCD_BACKSPACE_EN.
module bcd_operand_entry #(
    parameter int DIGIT_NUM = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   key_valid,
    input  logic [4:0]             key_code,
    output logic                   key_ready,
    output logic [4*DIGIT_NUM-1:0] op_a,
    output logic [4*DIGIT_NUM-1:0] op_b,
    output logic                   op_sub,
    output logic                   op_valid,
    input  logic                   op_ready,
    output logic                   edit_sel,
    output logic                   entry_full
);

    localparam int W  = 4 * DIGIT_NUM;
    localparam int CW = $clog2(DIGIT_NUM + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIGIT_NUM);

    typedef enum logic [1:0] {S_A, S_B, S_ISSUE, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    op_a_nxt, op_b_nxt;
    logic [CW-1:0]   cnt_a, cnt_b, cnt_a_nxt, cnt_b_nxt;
    logic            op_sub_nxt, entry_full_nxt;
    logic [W-1:0]    word, edit_word;
    logic [CW-1:0]   cnt, edit_cnt;
    logic            edit_full;
    logic            key_fire, is_digit;
    logic [3:0]      digit;

    // key_ready is gated by rst_n so no key can be accepted while reset is held
    assign key_ready = rst_n && (state != S_ISSUE);
    assign op_valid  = (state == S_ISSUE);
    assign edit_sel  = (state == S_B);
    assign key_fire  = key_valid && key_ready;
    assign is_digit  = (key_code <= 5'd9);
    assign digit     = key_code[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_A;
            op_a       <= '0;
            op_b       <= '0;
            cnt_a      <= '0;
            cnt_b      <= '0;
            op_sub     <= 1'b0;
            entry_full <= 1'b0;
        end else begin
            state      <= state_nxt;
            op_a       <= op_a_nxt;
            op_b       <= op_b_nxt;
            cnt_a      <= cnt_a_nxt;
            cnt_b      <= cnt_b_nxt;
            op_sub     <= op_sub_nxt;
            entry_full <= entry_full_nxt;
        end
    end

    // Edit of whichever word is active; the state logic decides where it lands
    always_comb begin
        word      = (state == S_B) ? op_b : op_a;
        cnt       = (state == S_B) ? cnt_b : cnt_a;
        edit_word = word;
        edit_cnt  = cnt;
        edit_full = entry_full;
        if (is_digit) begin
            if (!(cnt == '0 && digit == 4'd0)) begin
                if (cnt != CNT_FULL) begin
                    edit_word = {word[W-5:0], digit};
                    edit_cnt  = cnt + CW'(1);
                end else begin
                    edit_full = 1'b1;
                end
            end
`ifdef BCD_BACKSPACE_EN
        end else if (key_code == 5'd14) begin
            if (cnt != '0) begin
                edit_word = {4'h0, word[W-1:4]};
                edit_cnt  = cnt - CW'(1);
                edit_full = 1'b0;
            end
`endif
        end
    end

    always_comb begin
        state_nxt      = state;
        op_a_nxt       = op_a;
        op_b_nxt       = op_b;
        cnt_a_nxt      = cnt_a;
        cnt_b_nxt      = cnt_b;
        op_sub_nxt     = op_sub;
        entry_full_nxt = entry_full;
        if (key_fire && key_code == 5'd13) begin
            op_a_nxt       = '0;
            op_b_nxt       = '0;
            cnt_a_nxt      = '0;
            cnt_b_nxt      = '0;
            op_sub_nxt     = 1'b0;
            entry_full_nxt = 1'b0;
            state_nxt      = S_A;
        end else begin
            case (state)
                S_A: if (key_fire) begin
                    if (key_code == 5'd10 || key_code == 5'd11) begin
                        op_sub_nxt     = (key_code == 5'd11);
                        op_b_nxt       = '0;
                        cnt_b_nxt      = '0;
                        entry_full_nxt = 1'b0;
                        state_nxt      = S_B;
                    end else begin
                        op_a_nxt       = edit_word;
                        cnt_a_nxt      = edit_cnt;
                        entry_full_nxt = edit_full;
                    end
                end
                S_B: if (key_fire) begin
                    if (key_code == 5'd10 || key_code == 5'd11) begin
                        op_sub_nxt = (key_code == 5'd11);
                    end else if (key_code == 5'd12) begin
                        state_nxt = S_ISSUE;
                    end else begin
                        op_b_nxt       = edit_word;
                        cnt_b_nxt      = edit_cnt;
                        entry_full_nxt = edit_full;
                    end
                end
                S_ISSUE: if (op_ready) state_nxt = S_DONE;
                S_DONE: if (key_fire && is_digit) begin
                    // A zero digit leaves op_a at 0 with no digits counted
                    op_a_nxt       = W'(digit);
                    cnt_a_nxt      = (digit != 4'd0) ? CW'(1) : '0;
                    op_b_nxt       = '0;
                    cnt_b_nxt      = '0;
                    op_sub_nxt     = 1'b0;
                    entry_full_nxt = 1'b0;
                    state_nxt      = S_A;
                end
                default: state_nxt = S_A;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Directed bench for bcd_operand_entry: issued operand sets are scoreboarded and checked by a
// handshake monitor, other outputs are checked directly after each key.
module tb_bcd_operand_entry;

    localparam int DIGIT_NUM = 8;
    localparam int W = 4 * DIGIT_NUM;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          key_valid = 1'b0;
    logic [4:0]    key_code = '0;
    logic          key_ready;
    logic [W-1:0]  op_a, op_b;
    logic          op_sub, op_valid, edit_sel, entry_full;
    logic          op_ready = 1'b1;

    int n_compared   = 0;
    int n_mismatched = 0;
    logic [2*W:0] exp_q[$];

    bcd_operand_entry #(.DIGIT_NUM(DIGIT_NUM)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
        .op_valid(op_valid), .op_ready(op_ready), .edit_sel(edit_sel),
        .entry_full(entry_full)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One key per call, held for exactly one rising edge; outputs are sampled 1 ns after that edge
    task automatic apply_stimulus(input logic [4:0] code);
        @(posedge clk);
        #1;
        key_valid = 1'b1;
        key_code  = code;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && op_valid && op_ready) begin
            logic [2*W:0] e;
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected_issue: got a=%h b=%h sub=%b expected none", op_a, op_b, op_sub);
            end else begin
                e = exp_q.pop_front();
                check_output("issue_op_a", op_a, e[2*W:W+1]);
                check_output("issue_op_b", op_b, e[W:1]);
                check_output("issue_op_sub", W'(op_sub), W'(e[0]));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1;
        check_output("reset_key_ready", W'(key_ready), W'(0));
        check_output("reset_op_valid", W'(op_valid), W'(0));
        check_output("reset_op_a", op_a, '0);
        check_output("reset_edit_sel", W'(edit_sel), W'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // 12 - 7, issued for a single cycle
        apply_stimulus(5'd1);
        apply_stimulus(5'd2);
        apply_stimulus(5'd11);
        check_output("edit_sel_b", W'(edit_sel), W'(1));
        apply_stimulus(5'd7);
        exp_q.push_back({32'h12, 32'h7, 1'b1});
        apply_stimulus(5'd12);
        check_output("t1_valid_high", W'(op_valid), W'(1));
        @(posedge clk); #1;
        check_output("t1_valid_low", W'(op_valid), W'(0));

        // leading zeros suppressed, overflow sets entry_full
        apply_stimulus(5'd0);
        apply_stimulus(5'd0);
        apply_stimulus(5'd5);
        check_output("lead_zero_a", op_a, 32'h5);
        for (int i = 1; i <= 9; i++) begin
            apply_stimulus(5'd1);
            if (i == 7) check_output("full_not_yet", W'(entry_full), W'(0));
            if (i == 8) check_output("full_set", W'(entry_full), W'(1));
        end
        check_output("t2_op_a", op_a, 32'h51111111);
        apply_stimulus(5'd10);
        check_output("op_clears_full", W'(entry_full), W'(0));
        check_output("op_clears_b", op_b, '0);
        apply_stimulus(5'd9);
        apply_stimulus(5'd8);
        apply_stimulus(5'd11);
        check_output("sub_keeps_b", op_b, 32'h98);
        check_output("sub_replaced", W'(op_sub), W'(1));

        // hold issue for 5 cycles with a blocked clear key pending
        op_ready = 1'b0;
        exp_q.push_back({32'h51111111, 32'h98, 1'b1});
        apply_stimulus(5'd12);
        key_valid = 1'b1;
        key_code  = 5'd13;
        for (int i = 0; i < 5; i++) begin
            check_output("hold_valid", W'(op_valid), W'(1));
            check_output("hold_key_ready", W'(key_ready), W'(0));
            check_output("hold_op_a", op_a, 32'h51111111);
            check_output("hold_op_b", op_b, 32'h98);
            @(posedge clk); #1;
        end
        key_valid = 1'b0;
        op_ready  = 1'b1;
        @(posedge clk); #1;
        check_output("done_valid", W'(op_valid), W'(0));
        check_output("done_key_ready", W'(key_ready), W'(1));
        check_output("done_edit_sel", W'(edit_sel), W'(0));

        // digit after done restarts entry; invalid and '=' ignored in S_A
        apply_stimulus(5'd4);
        check_output("restart_a", op_a, 32'h4);
        check_output("restart_b", op_b, '0);
        check_output("restart_sub", W'(op_sub), W'(0));
        apply_stimulus(5'd20);
        apply_stimulus(5'd12);
        check_output("ignored_a", op_a, 32'h4);
        check_output("ignored_sel", W'(edit_sel), W'(0));
        apply_stimulus(5'd10);
        apply_stimulus(5'd3);
        check_output("b_entry", op_b, 32'h3);
        apply_stimulus(5'd13);
        check_output("clear_a", op_a, '0);
        check_output("clear_b", op_b, '0);
        check_output("clear_sel", W'(edit_sel), W'(0));

        // reset during issue
        apply_stimulus(5'd6);
        apply_stimulus(5'd11);
        apply_stimulus(5'd2);
        op_ready = 1'b0;
        apply_stimulus(5'd12);
        check_output("pre_reset_valid", W'(op_valid), W'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_valid", W'(op_valid), W'(0));
        check_output("async_key_ready", W'(key_ready), W'(0));
        check_output("async_op_a", op_a, '0);
        op_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_output("post_reset_ready", W'(key_ready), W'(1));
        apply_stimulus(5'd2);
        check_output("post_reset_a", op_a, 32'h2);
        check_output("post_reset_sel", W'(edit_sel), W'(0));

        // backspace
        apply_stimulus(5'd13);
        apply_stimulus(5'd3);
        apply_stimulus(5'd4);
        apply_stimulus(5'd14);
`ifdef BCD_BACKSPACE_EN
        check_output("backspace_a", op_a, 32'h3);
`else
        check_output("backspace_a", op_a, 32'h34);
`endif

        @(posedge clk); #1;
        check_output("scoreboard_drained", W'(exp_q.size()), W'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
